// File: rtl/bcd_convert_sched.sv
// Shared binary-to-BCD engine. It arbitrates round-robin among NUM_REQ requesters and runs one double-dabble step per clock.
// Define BCD_BLANK_EN to output leading zero digits as 4'hF (blank code). The units digit is never blanked.
module bcd_convert_sched #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 32,
    parameter int DIGITS  = 10,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic                       done,
    output logic [ID_W-1:0]            done_id,
    output logic [4*DIGITS-1:0]        bcd_out,
    output logic                       neg,
    output logic                       ovf
);
    localparam int BW = 4*DIGITS;
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, cur_q, cur_d, did_q, did_d, win, nxt;
    logic [WIDTH-1:0]  mag_q, mag_d, op;
    logic [BW-1:0]     scr_q, scr_d, bcd_q, bcd_d, adj, step_scr, shown;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sov_q, sov_d, sgn_q, sgn_d, neg_q, neg_d, ovf_q, ovf_d;
    logic [2*NUM_REQ-1:0] req_rot;
    logic              found;
    logic [ID_W:0]     sum;

    // Rotate requests so that bit 0 is the requester at ptr. The lowest set bit wins.
    always_comb begin
        req_rot = {req, req} >> ptr_q;
        found   = 1'b0;
        sum     = '0;
        for (int o = NUM_REQ-1; o >= 0; o--) begin
            if (req_rot[o]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (ID_W+1)'(o);
            end
        end
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        win = sum[ID_W-1:0];
        nxt = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
        op  = req_data[win*WIDTH +: WIDTH];
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next magnitude bit.
    always_comb begin
        adj = scr_q;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3 : scr_q[4*k +: 4];
        step_scr = {adj[BW-2:0], mag_q[WIDTH-1]};
    end

`ifdef BCD_BLANK_EN
    logic lead;
    always_comb begin
        shown = step_scr;
        lead  = 1'b1;
        for (int k = DIGITS-1; k >= 0; k--) begin
            if (step_scr[4*k +: 4] != 4'd0) lead = 1'b0;
            if (lead && k != 0) shown[4*k +: 4] = 4'hF;
        end
    end
`else
    assign shown = step_scr;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        did_d   = did_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        sov_d   = sov_q;
        sgn_d   = sgn_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        grant   = '0;
        unique case (state_q)
            S_IDLE: if (found) begin
                grant[win] = 1'b1;
                mag_d   = op[WIDTH-1] ? (~op + 1'b1) : op;
                sgn_d   = op[WIDTH-1];
                scr_d   = '0;
                sov_d   = 1'b0;
                cnt_d   = CW'(WIDTH);
                cur_d   = win;
                ptr_d   = nxt;
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                scr_d = step_scr;
                mag_d = mag_q << 1;
                sov_d = sov_q | adj[BW-1];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shown;
                    neg_d   = sgn_q;
                    ovf_d   = sov_q | adj[BW-1];
                    did_d   = cur_q;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
            did_q   <= '0;
            mag_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            sov_q   <= 1'b0;
            sgn_q   <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            did_q   <= did_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            sov_q   <= sov_d;
            sgn_q   <= sgn_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign done_id = did_q;
    assign bcd_out = bcd_q;
    assign neg     = neg_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_convert_sched.sv
// Directed bench for bcd_convert_sched: a default-size instance plus a DIGITS=8 instance for overflow.
module tb_bcd_convert_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  grant;
    logic        busy, done, neg, ovf;
    logic [1:0]  done_id;
    logic [39:0] bcd_out;

    logic        req8 = 1'b0;
    logic [31:0] data8 = '0;
    logic        grant8, busy8, done8, neg8, ovf8;
    logic        done_id8;
    logic [31:0] bcd8;

    int nchk = 0;
    int nfail = 0;

    logic [39:0] E_12345, E_1, E_7, E_25, E_1000, E_407, E_0;

    always #5 clk = ~clk;

    bcd_convert_sched #(.NUM_REQ(3), .WIDTH(32), .DIGITS(10), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
        .busy(busy), .done(done), .done_id(done_id), .bcd_out(bcd_out), .neg(neg), .ovf(ovf));

    bcd_convert_sched #(.NUM_REQ(1), .WIDTH(32), .DIGITS(8), .ID_W(1)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .req_data(data8), .grant(grant8),
        .busy(busy8), .done(done8), .done_id(done_id8), .bcd_out(bcd8), .neg(neg8), .ovf(ovf8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request with mask; requester gid must win. Checks grant, latency, result and the one-cycle done pulse.
    task automatic run(input string tag, input logic [2:0] mask, input int gid, input logic [31:0] d,
                       input logic [39:0] eb, input logic en, input logic eo);
        int n;
        @(negedge clk);
        req_data[gid*32 +: 32] = d;
        req = mask;
        #1;
        chk({tag, ".grant"}, grant, 64'(1) << gid);
        @(negedge clk);
        req = '0;
        req_data[gid*32 +: 32] = ~d;
        chk({tag, ".busy"}, busy, 1);
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, 33);
        chk({tag, ".bcd"}, bcd_out, eb);
        chk({tag, ".neg"}, neg, en);
        chk({tag, ".ovf"}, ovf, eo);
        chk({tag, ".id"}, done_id, gid);
        @(negedge clk);
        chk({tag, ".pulse"}, {done, busy}, 0);
    endtask

    task automatic run8(input string tag, input logic [31:0] d, input logic [31:0] eb,
                        input logic eo, input logic check_bcd);
        int n;
        @(negedge clk);
        data8 = d;
        req8 = 1'b1;
        @(negedge clk);
        req8 = 1'b0;
        n = 1;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, 33);
        chk({tag, ".ovf"}, ovf8, eo);
        if (check_bcd) chk({tag, ".bcd"}, bcd8, eb);
    endtask

    initial begin
        int ng, nd, cyc, nd_bad;
        logic [2:0]  gr [4];
        logic [1:0]  dids [4];
        int          dc [4];
        logic [39:0] db [4];
        logic        dn [4];
`ifdef BCD_BLANK_EN
        E_12345 = 40'hFFFFF12345; E_1 = 40'hFFFFFFFFF1; E_7 = 40'hFFFFFFFFF7;
        E_25 = 40'hFFFFFFFF25; E_1000 = 40'hFFFFFF1000; E_407 = 40'hFFFFFFF407; E_0 = 40'hFFFFFFFFF0;
`else
        E_12345 = 40'h0000012345; E_1 = 40'h0000000001; E_7 = 40'h0000000007;
        E_25 = 40'h0000000025; E_1000 = 40'h0000001000; E_407 = 40'h0000000407; E_0 = 40'h0000000000;
`endif
        repeat (2) @(negedge clk);
        chk("rst.outs", {busy, done, done_id, neg, ovf, grant}, 0);
        chk("rst.bcd", bcd_out, 0);
        rst_n = 1'b1;

        run("t1_12345", 3'b001, 0, 32'd12345, E_12345, 1'b0, 1'b0);
        run("t2_m1", 3'b001, 0, 32'hFFFFFFFF, E_1, 1'b1, 1'b0);
        run("t2_min", 3'b001, 0, 32'h80000000, 40'h2147483648, 1'b1, 1'b0);

        // Reset 10 cycles into a conversion for requester 1 (ptr is 1 here).
        @(negedge clk);
        req_data[63:32] = 32'd999;
        req = 3'b010;
        #1;
        chk("t4.grant", grant, 3'b010);
        @(negedge clk);
        req = '0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4.rst_outs", {busy, done, neg, ovf}, 0);
        chk("t4.rst_bcd", bcd_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd_bad++;
        end
        chk("t4.no_done", nd_bad, 0);
        // ptr back at 0: with requesters 1 and 2 pending, 1 wins.
        run("t4_after", 3'b110, 1, 32'd407, E_407, 1'b0, 1'b0);
        run("t6_zero", 3'b001, 0, 32'd0, E_0, 1'b0, 1'b0);

        // All requesters held; ptr is 1 now, so reset again to start from 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data = {32'd1000, 32'hFFFFFFE7, 32'd7};
        req = 3'b111;
        ng = 0; nd = 0; cyc = 0;
        while (nd < 4 && cyc < 400) begin
            #1;
            if (grant != 3'b000 && ng < 4) begin gr[ng] = grant; ng++; end
            if (done) begin
                dids[nd] = done_id; dc[nd] = cyc; db[nd] = bcd_out; dn[nd] = neg;
                nd++;
            end
            @(negedge clk);
            cyc++;
        end
        req = '0;
        chk("t3.ndone", nd, 4);
        chk("t3.ngrant", ng, 4);
        chk("t3.grants", {gr[0], gr[1], gr[2], gr[3]}, {3'b001, 3'b010, 3'b100, 3'b001});
        chk("t3.ids", {dids[0], dids[1], dids[2], dids[3]}, {2'd0, 2'd1, 2'd2, 2'd0});
        chk("t3.gap01", dc[1] - dc[0], 34);
        chk("t3.gap12", dc[2] - dc[1], 34);
        chk("t3.gap23", dc[3] - dc[2], 34);
        chk("t3.bcd0", db[0], E_7);
        chk("t3.bcd1", db[1], E_25);
        chk("t3.bcd2", db[2], E_1000);
        chk("t3.bcd3", db[3], E_7);
        chk("t3.neg", {dn[0], dn[1], dn[2], dn[3]}, 4'b0100);

        run8("t5_ovf", 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0);
        run8("t5_fit", 32'd99999999, 32'h99999999, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
